box_draw_scheduler: RTL and testbench
=====================================

# box_draw_scheduler

Sequences the 4x4-pixel box datapath for the Simon Says display. On a start strobe it latches the direction code and the four box origins, then streams one pixel per clock to the VGA adapter, drawing each of the four boxes in turn. The selected box is drawn in the highlight colour and the others in the base colour. It sits between the game FSM, which issues the direction and start, and the VGA adapter's x/y/colour/plot inputs.

## Interface
- `LOG2_DIM`, default 2: box edge is 2^LOG2_DIM pixels, so the default is 4x4.
- `HI_COLOUR`, default 3'b010: colour of the selected box.
- `BASE_COLOUR`, default 3'b111: colour of unselected boxes.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to draw a frame; honoured only in IDLE.
- `direction`  in  3  selects the box to highlight:
  - 000 left, 001 down, 010 up, 011 right.
  - 1xx: no highlight, all boxes drawn in the base colour.
- `box_left`, `box_down`, `box_up`, `box_right`  in  16 each  box origin: [14:7]=x, [6:0]=y, [15] ignored.
- `vga_x`  out  8  pixel x.
- `vga_y`  out  7  pixel y.
- `vga_colour`  out  3  pixel colour.
- `plot`  out  1  pixel write enable.
- `busy`  out  1  high from the cycle after start is accepted until DONE exits.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States: IDLE, DRAW, DONE (plus CLEAR when `BOX_CLEAR_EN` is defined).
- IDLE:
  - `start`=1 latches `direction` and all four origins.
  - Then clears the box index and pixel counter, and goes to DRAW (or CLEAR).
- DRAW:
  - Box order is fixed: left(0), down(1), up(2), right(3).
  - Pixel counter is 2*LOG2_DIM bits: low half is column, high half is row, column-fastest raster.
  - Each cycle emits one pixel with `plot`=1: x = origin_x + col (mod 256), y = origin_y + row (mod 128), plain truncation, no clipping.
  - Colour is HI_COLOUR when the box index equals the latched direction (direction[2]=0), otherwise BASE_COLOUR.
  - When the counter wraps at all-ones, the box index increments.
  - After pixel (last, last) of box 3, go to DONE.
- DONE: `done`=1 and `plot`=0 for one cycle, then IDLE.
- Inputs latched at start are held for the whole frame; changes to `direction` or the origins mid-frame have no effect.
- `start` while busy is ignored, with no queuing.
- `start` in the DONE cycle is ignored.
- Reset at any time, including mid-frame:
  - Immediately returns to IDLE.
  - All outputs go to their reset values; the partial frame is abandoned.

## Timing
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=0, `plot`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` sampled high at edge N:
  - First pixel, box 0 at (0,0), is valid after edge N+1.
  - Pixels continue on every consecutive cycle with no gaps.
- Frame length is 4·2^(2·LOG2_DIM) plot cycles: 64 at the default.
- `done` is high for the single cycle after the last plot; `busy` falls with `done`.
- Next accepted `start` is sampled no earlier than the cycle after DONE.

## Configuration
- `BOX_CLEAR_EN` defined:
  - A CLEAR pass precedes DRAW, walking all four boxes in the same order with colour 3'b000 and `plot`=1.
  - Frame length doubles: 128 plot cycles at the default.
  - `busy` covers both passes; `done` fires only after DRAW.
- `BOX_CLEAR_EN` undefined: there is no CLEAR state, and IDLE goes directly to DRAW.

## Test plan
- Reset then idle:
  - Hold `resetn`=0 for 3 cycles, release, wait 10 cycles.
  - All outputs stay 0, `plot` never asserts.
- Highlight up:
  - direction=010, left origin=(10,20), up origin=(40,5), pulse start.
  - Exactly 64 plots.
  - Plots 0..15: x 10..13, y 20..23, colour 111.
  - Plots 32..47: x 40..43, y 5..8, colour 010.
  - `done` pulses the cycle after plot 63.
- All white:
  - direction=100.
  - All 64 pixels have colour 111; no pixel uses 010.
- Wrap-around:
  - right origin=(254,126), direction=011.
  - Box 3 pixel coordinates: x in {254,255,0,1}, y in {126,127,0,1}, colour 010.
- Mid-frame disturbance:
  - Change direction and pulse start at plot 20: output is unchanged.
  - Assert `resetn`=0 at plot 30: `plot`=0 and `busy`=0 immediately.
  - A new start after release draws a full 64-pixel frame.
- `BOX_CLEAR_EN`:
  - 128 plots; the first 64 have colour 000.
  - Timing of the second 64 matches the highlight-up scenario; `done` occurs once.

Source files
------------

// File: rtl/box_draw_if.sv
// Handshake and pixel bus between the game FSM (master) and box_draw_scheduler (slave).
interface box_draw_if;
    logic        start;
    logic [2:0]  direction;
    logic [15:0] box_left;
    logic [15:0] box_down;
    logic [15:0] box_up;
    logic [15:0] box_right;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, direction, box_left, box_down, box_up, box_right,
        input  vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        input  start, direction, box_left, box_down, box_up, box_right,
        output vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/box_draw_scheduler.sv
// Streams the four Simon Says boxes to the VGA adapter, one pixel per clock.
// Optional BOX_CLEAR_EN adds a black clearing pass ahead of the draw pass.
module box_draw_scheduler #(
    parameter int         LOG2_DIM    = 2,
    parameter logic [2:0] HI_COLOUR   = 3'b010,
    parameter logic [2:0] BASE_COLOUR = 3'b111
) (
    input  logic      clock,
    input  logic      resetn,
    box_draw_if.slave bus
);
    localparam int CNT_W = 2 * LOG2_DIM;
    localparam int POS_W = CNT_W + 2;

`ifdef BOX_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2, CLEAR = 2'd3} state_t;
    localparam state_t FIRST_PASS = CLEAR;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;
    localparam state_t FIRST_PASS = DRAW;
`endif

    state_t state_reg, state_next;

    logic [2:0]       dir_reg;
    logic [14:0]      origin_reg [4];
    logic [7:0]       org_x [4];
    logic [6:0]       org_y [4];
    logic [POS_W-1:0] pos_reg;

    logic [7:0] vga_x_reg, vga_x_next;
    logic [6:0] vga_y_reg, vga_y_next;
    logic [2:0] colour_reg, colour_next;
    logic       plot_reg, plot_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    logic [1:0]          box_idx;
    logic [LOG2_DIM-1:0] col;
    logic [LOG2_DIM-1:0] row;
    logic [7:0]          pix_x;
    logic [6:0]          pix_y;
    logic                frame_last;
    logic                start_ok;
    logic                walking;
    logic                unused_msbs;

    assign unused_msbs = ^{bus.box_left[15], bus.box_down[15], bus.box_up[15], bus.box_right[15]};

    // The done cycle is visible while the state is already IDLE, so a start
    // landing in that cycle must still be refused.
    assign start_ok = bus.start && !done_reg;

    assign box_idx    = pos_reg[POS_W-1:CNT_W];
    assign col        = pos_reg[LOG2_DIM-1:0];
    assign row        = pos_reg[CNT_W-1:LOG2_DIM];
    assign frame_last = &pos_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_origin
            assign org_x[gi] = origin_reg[gi][14:7];
            assign org_y[gi] = origin_reg[gi][6:0];
        end
    endgenerate

    assign pix_x = org_x[box_idx] + {{(8 - LOG2_DIM){1'b0}}, col};
    assign pix_y = org_y[box_idx] + {{(7 - LOG2_DIM){1'b0}}, row};

`ifdef BOX_CLEAR_EN
    assign walking = (state_reg == DRAW) || (state_reg == CLEAR);
`else
    assign walking = (state_reg == DRAW);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start_ok) state_next = FIRST_PASS;
`ifdef BOX_CLEAR_EN
            CLEAR: if (frame_last) state_next = DRAW;
`endif
            DRAW:  if (frame_last) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vga_x_next  = '0;
        vga_y_next  = '0;
        colour_next = '0;
        plot_next   = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: busy_next = start_ok;
`ifdef BOX_CLEAR_EN
            CLEAR: begin
                vga_x_next = pix_x;
                vga_y_next = pix_y;
                plot_next  = 1'b1;
                busy_next  = 1'b1;
            end
`endif
            DRAW: begin
                vga_x_next  = pix_x;
                vga_y_next  = pix_y;
                colour_next = (!dir_reg[2] && dir_reg[1:0] == box_idx) ? HI_COLOUR : BASE_COLOUR;
                plot_next   = 1'b1;
                busy_next   = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
                busy_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Box index and pixel counter form one counter, so a wrap of the pixel
    // counter carries straight into the next box (and from CLEAR into DRAW).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_x_reg  <= '0;
            vga_y_reg  <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dir_reg    <= '0;
            pos_reg    <= '0;
            for (int i = 0; i < 4; i++) origin_reg[i] <= '0;
        end else begin
            vga_x_reg  <= vga_x_next;
            vga_y_reg  <= vga_y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            if (state_reg == IDLE) begin
                pos_reg <= '0;
                if (start_ok) begin
                    dir_reg       <= bus.direction;
                    origin_reg[0] <= bus.box_left[14:0];
                    origin_reg[1] <= bus.box_down[14:0];
                    origin_reg[2] <= bus.box_up[14:0];
                    origin_reg[3] <= bus.box_right[14:0];
                end
            end else if (walking) begin
                pos_reg <= pos_reg + POS_W'(1);
            end
        end
    end

    assign bus.vga_x      = vga_x_reg;
    assign bus.vga_y      = vga_y_reg;
    assign bus.vga_colour = colour_reg;
    assign bus.plot       = plot_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_box_draw_scheduler.sv
// Randomised frame bench for box_draw_scheduler against an arithmetic pixel model.
module tb_box_draw_scheduler;
    localparam int DIM  = 4;
    localparam int NPIX = DIM * DIM;
`ifdef BOX_CLEAR_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int TOTAL = PASSES * 4 * NPIX;

    logic clock = 1'b0;
    logic resetn;
    int   tests_run    = 0;
    int   tests_failed = 0;

    int   m_dir;
    int   m_ox [4];
    int   m_oy [4];

    box_draw_if bus ();

    box_draw_scheduler dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] org(input int x, input int y);
        logic [7:0] xs;
        logic [6:0] ys;
        logic       junk;
        xs   = 8'(x);
        ys   = 7'(y);
        junk = 1'($urandom);
        return {junk, xs, ys};
    endfunction

    function automatic logic [15:0] rand_org();
        return org(int'($urandom_range(255)), int'($urandom_range(127)));
    endfunction

    // Expected {plot,x,y,colour} of the i-th plotted pixel of a frame.
    function automatic logic [31:0] exp_pixel(input int i);
        int j, b, p, x, y, c;
        bit clearing;
        clearing = (PASSES == 2) && (i < 4 * NPIX);
        j = i % (4 * NPIX);
        b = j / NPIX;
        p = j % NPIX;
        x = (m_ox[b] + p % DIM) % 256;
        y = (m_oy[b] + p / DIM) % 128;
        if (clearing)                  c = 0;
        else if (m_dir < 4 && m_dir == b) c = 2;
        else                           c = 7;
        return {13'd0, 1'b1, 8'(x), 7'(y), 3'(c)};
    endfunction

    function automatic logic [31:0] obs_pixel();
        return {13'd0, bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour};
    endfunction

    function automatic logic [31:0] obs_all();
        return {11'd0, bus.vga_x, bus.vga_y, bus.vga_colour, bus.plot, bus.busy, bus.done};
    endfunction

    task automatic run_frame(input logic [2:0] dir, input logic [15:0] o0, input logic [15:0] o1,
                             input logic [15:0] o2, input logic [15:0] o3,
                             input int disturb_at, input int reset_at);
        logic [15:0] os [4];
        os = '{o0, o1, o2, o3};
        m_dir = int'(dir);
        for (int k = 0; k < 4; k++) begin
            m_ox[k] = int'(os[k][14:7]);
            m_oy[k] = int'(os[k][6:0]);
        end
        bus.direction = dir;
        bus.box_left  = o0;
        bus.box_down  = o1;
        bus.box_up    = o2;
        bus.box_right = o3;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("accept", {30'd0, bus.busy, bus.plot}, 32'b10);
        for (int i = 0; i < TOTAL; i++) begin
            @(negedge clock);
            check($sformatf("pix%0d", i), obs_pixel(), exp_pixel(i));
            bus.start = (i == disturb_at);
            if (i == disturb_at) begin
                bus.direction = 3'($urandom);
                bus.box_left  = rand_org();
                bus.box_down  = rand_org();
                bus.box_up    = rand_org();
                bus.box_right = rand_org();
            end
            if (i == reset_at) begin
                resetn = 1'b0;
                #1;
                check("reset_mid", obs_all(), 32'd0);
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
        end
        @(negedge clock);
        check("done_cycle", {29'd0, bus.done, bus.plot, bus.busy}, 32'b101);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("after_done", {29'd0, bus.done, bus.plot, bus.busy}, 32'b000);
        @(negedge clock);
        check("start_in_done_ignored", {30'd0, bus.busy, bus.plot}, 32'b00);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.direction = '0;
        bus.box_left  = '0;
        bus.box_down  = '0;
        bus.box_up    = '0;
        bus.box_right = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("in_reset", obs_all(), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle", obs_all(), 32'd0);
        end

        run_frame(3'b010, org(10, 20), rand_org(), org(40, 5), rand_org(), -1, -1);
        run_frame(3'b100, rand_org(), rand_org(), rand_org(), rand_org(), -1, -1);
        run_frame(3'b011, rand_org(), rand_org(), rand_org(), org(254, 126), -1, -1);

        run_frame(3'b001, rand_org(), rand_org(), rand_org(), rand_org(), 20, 30);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("idle_after_reset", obs_all(), 32'd0);
        end
        run_frame(3'b000, rand_org(), rand_org(), rand_org(), rand_org(), -1, -1);

        for (int f = 0; f < 4; f++) begin
            run_frame(3'($urandom), rand_org(), rand_org(), rand_org(), rand_org(), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
